instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL set the PC value loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 8'hFF, SHALL be the opcode that stops fetching.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_req  output  1  SHALL request a program-memory read at mem_addr.
REQ-006 mem_addr  output  8  SHALL carry the program-memory read address (equals pc).
REQ-007 mem_ack  input  1  SHALL indicate that mem_data is valid for the current request.
REQ-008 mem_data  input  8  SHALL carry the instruction byte returned by memory.
REQ-009 stall  input  1  SHALL, when high, hold the issued instruction (downstream busy).
REQ-010 ir  output  8  SHALL be the instruction register that feeds the decoder.
REQ-011 ir_valid  output  1  SHALL be high while ir holds a newly fetched, unconsumed instruction.
REQ-012 pc  output  8  SHALL be the address of the next instruction to fetch.
REQ-013 halted  output  1  SHALL be high once HALT_OPCODE has been issued.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, REQ, ISSUE and HALT.
REQ-015 All outputs SHALL be decoded from registered state only (Moore); no combinational input-to-output paths.
REQ-016 IDLE SHALL last one cycle after reset deassertion, then move to REQ.
REQ-017 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal pc, held stable until mem_ack is sampled high.
REQ-018 On mem_ack in REQ, the block SHALL load ir<=mem_data, set pc<=pc+1 and move to ISSUE; mem_ack in the first REQ cycle counts.
REQ-019 pc SHALL increment modulo 256 (8'hFF+1 -> 8'h00) with no flag.
REQ-020 In ISSUE, ir_valid SHALL be 1 and mem_req SHALL be 0.
REQ-021 In ISSUE with stall=1, ir, pc and ir_valid SHALL hold unchanged.
REQ-022 In ISSUE with stall=0, the instruction is consumed: next state SHALL be HALT if ir==HALT_OPCODE, else REQ.
REQ-023 Minimum throughput SHALL be one instruction per 2 cycles (REQ with same-cycle ack, then ISSUE).
REQ-024 mem_ack SHALL be ignored in IDLE, ISSUE and HALT.
REQ-025 In HALT: halted=1, mem_req=0, ir_valid=0, ir and pc frozen; only reset exits.
REQ-026 ir SHALL change only on the REQ->ISSUE transition.

Reset
REQ-027 Asserting reset SHALL immediately force state=IDLE, pc=RESET_PC, ir=8'h00, ir_valid=0, mem_req=0, halted=0.
REQ-028 Reset asserted mid-request or mid-stall SHALL abort that operation; the aborted fetch SHALL NOT be re-issued or counted.

Configuration
REQ-029 With INSTR_FETCH_COUNT_EN defined, a 16-bit output instr_count SHALL count consumed instructions (ISSUE with stall=0), saturate at 16'hFFFF, and reset to 0.
REQ-030 Without INSTR_FETCH_COUNT_EN, the instr_count port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset release, memory {00:8'h01,01:8'h02}, mem_ack same cycle as mem_req, stall=0 -> ir=8'h01 with ir_valid at cycle 3, ir=8'h02 at cycle 5, pc=8'h02.
REQ-032 mem_ack delayed 3 cycles -> mem_req and mem_addr=8'h00 stable for 4 cycles, ir_valid rises the cycle after ack.
REQ-033 stall=1 for 5 cycles during ISSUE with ir=8'h02 -> ir/ir_valid/pc unchanged, mem_req=0 throughout, fetch resumes one cycle after stall drops.
REQ-034 Memory at 8'h03 holds 8'hFF -> after its consumption halted=1, mem_req=0, pc=8'h04 permanently; mem_ack pulses ignored.
REQ-035 RESET_PC=8'hFF, memory{FF:8'h01} -> first fetch at 8'hFF, next mem_addr=8'h00.
REQ-036 Reset asserted while mem_req=1 waiting for ack -> mem_req=0 same cycle, pc=RESET_PC, instr_count (if enabled)=0.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Four-state Moore instruction fetch unit. Reads one byte per instruction
//   from program memory at pc, holds it in ir for the decoder, and stops
//   permanently once HALT_OPCODE has been consumed.
//
//   Parameters
//     RESET_PC     PC value loaded on reset
//     HALT_OPCODE  opcode that stops fetching once it is consumed
//
//   Ports
//     clk          single clock, rising edge
//     reset        asynchronous, active-high reset
//     mem_req      program-memory read request (high in REQ)
//     mem_addr     program-memory read address (always equals pc)
//     mem_ack      mem_data valid for the current request
//     mem_data     instruction byte returned by memory
//     stall        downstream busy; holds the issued instruction
//     ir           instruction register feeding the decoder
//     ir_valid     ir holds a newly fetched, unconsumed instruction
//     pc           address of the next instruction to fetch
//     halted       HALT_OPCODE has been consumed
//     instr_count  (INSTR_FETCH_COUNT_EN only) saturating count of
//                  consumed instructions
//
//   Optional feature macro: INSTR_FETCH_COUNT_EN
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    input  logic        stall,
    output logic [7:0]  ir,
    output logic        ir_valid,
    output logic [7:0]  pc,
    output logic        halted
`ifdef INSTR_FETCH_COUNT_EN
    ,
    output logic [15:0] instr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  pc_r;
    logic [7:0]  ir_r;
    logic        fetch_done_s;
    logic        consume_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and the fetch/consume strobes used by the datapath
    always_comb begin
        state_next_s = state_r;
        fetch_done_s = 1'b0;
        consume_s    = 1'b0;
        case (state_r)
            IDLE: begin
                state_next_s = REQ;
            end
            REQ: begin
                // An ack in the very first REQ cycle is accepted, giving
                // the two-cycle best-case throughput.
                if (mem_ack) begin
                    fetch_done_s = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = REQ;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    consume_s    = 1'b1;
                    state_next_s = (ir_r == HALT_OPCODE) ? HALT : REQ;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            HALT: begin
                state_next_s = HALT;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // PC and instruction register: both change only on a completed fetch,
    // so stalls, halt and ignored acks leave them frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
            ir_r <= 8'h00;
        end else if (fetch_done_s) begin
            pc_r <= pc_r + 8'd1;
            ir_r <= mem_data;
        end else begin
            pc_r <= pc_r;
            ir_r <= ir_r;
        end
    end

`ifdef INSTR_FETCH_COUNT_EN
    logic [15:0] count_r;

    // Saturating count of consumed instructions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 16'h0000;
        end else if (consume_s && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign instr_count = count_r;
`endif

    // Moore outputs decoded from registered state only
    assign mem_req  = (state_r == REQ);
    assign mem_addr = pc_r;
    assign ir_valid = (state_r == ISSUE);
    assign halted   = (state_r == HALT);
    assign ir       = ir_r;
    assign pc       = pc_r;

endmodule
